// File: rtl/uart_mmio_responder_pkg.sv
// Shared types for the UART MMIO responder: bus request encodings, register
// map, control-word layout, baud rates and the serial FSM state encodings.
package uart_mmio_responder_pkg;

  localparam int ARCH_WIDTH = 32;
  localparam int UART_SIZE  = 12;

  typedef enum logic [31:0] {
    BR_9600   = 32'd9600,
    BR_19200  = 32'd19200,
    BR_38400  = 32'd38400,
    BR_57600  = 32'd57600,
    BR_115200 = 32'd115200
  } uart_baud_rate_t;

  typedef enum logic {
    DMEM_READ  = 1'b0,
    DMEM_WRITE = 1'b1
  } dmem_rtype_t;

  typedef enum logic [2:0] {
    DMEM_BYTE   = 3'd0,
    DMEM_HALF   = 3'd1,
    DMEM_WORD   = 3'd2,
    DMEM_BYTE_U = 3'd4,
    DMEM_HALF_U = 3'd5
  } dmem_dtype_t;

  // Register index taken from addr[3:2]; index 3 is unmapped.
  typedef enum logic [1:0] {
    UART_CTRL = 2'd0,
    UART_RX   = 2'd1,
    UART_TX   = 2'd2,
    UART_NONE = 2'd3
  } uart_addr_t;

  typedef struct packed {
    logic [29:0] rsvd;
    logic        rx_valid;
    logic        tx_ready;
  } uart_ctrl_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_t;

  // Zero-extend a UART byte onto the load data bus.
  function automatic logic [ARCH_WIDTH-1:0] zext_byte(input logic [7:0] b);
    return {{(ARCH_WIDTH-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_bit_engine.sv
// Serial bit engine: TX shifter and RX deserializer, each with its own baud
// counter. RX input is synchronized here; completed bytes are reported with a
// one-cycle registered pulse.
module uart_bit_engine
  import uart_mmio_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_uart_tx,
  input  logic       i_uart_rx,
  output logic       o_rx_done,
  output logic [7:0] o_rx_byte
);

  // CLKS_PER_BIT must be at least 4 so the half-bit count is meaningful.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_tx_state_t   r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx_line;
  logic             r_tx_ready;

  uart_rx_state_t   r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_armed;
  logic             r_rx_done;
  logic [7:0]       r_rx_byte;

  assign o_tx_ready = r_tx_ready;
  assign o_uart_tx  = r_tx_line;
  assign o_rx_done  = r_rx_done;
  assign o_rx_byte  = r_rx_byte;

  // TX shifter: start bit, 8 data bits LSB first, stop bit; line is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_tx_line  <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (i_tx_start) begin
            r_tx_state <= TX_START;
            r_tx_cnt   <= '0;
            r_tx_shift <= i_tx_byte;
            r_tx_line  <= 1'b0;
            r_tx_ready <= 1'b0;
          end
        end
        TX_START: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_line  <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx_line  <= 1'b1;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX deserializer: mid-bit sampling, glitch rejection, framing check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_rx_armed <= 1'b0;
      r_rx_done  <= 1'b0;
      r_rx_byte  <= 8'd0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          // Only a high-to-low transition seen after the line was high starts a frame.
          if (r_rx_sync) begin
            r_rx_armed <= 1'b1;
          end else if (r_rx_armed) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_bit   <= 3'd0;
              r_rx_state <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_armed <= 1'b0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_rx_done <= 1'b1;
              r_rx_byte <= r_rx_shift;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
          r_rx_armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// UART MMIO responder: decodes ctrl/rx_data/tx_data, returns load data one
// cycle after a read, and owns the rx_valid/rx_data/tx_data registers.
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int              CLOCK_FREQ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE  = BR_115200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rtype,
  input  logic [2:0]            req_dtype,
  input  logic [ARCH_WIDTH-1:0] req_addr,
  input  logic [ARCH_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [ARCH_WIDTH-1:0] rsp_data,
  input  logic                  uart_rx,
  output logic                  uart_tx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / int'(BAUD_RATE);

  uart_addr_t            w_sel;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_tx_start;
  logic                  w_tx_ready;
  logic                  w_rx_done;
  logic [7:0]            w_rx_byte;
  uart_ctrl_t            w_ctrl;
  logic [ARCH_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  logic                  r_rsp_valid;
  logic [ARCH_WIDTH-1:0] r_rsp_data;
  logic                  r_rx_valid;
  logic [7:0]            r_rx_data;
  logic [7:0]            r_tx_data;

  // Access size and the bits outside addr[3:2] play no part in decode.
  assign w_unused = ^{req_dtype, req_addr[ARCH_WIDTH-1:4], req_addr[1:0],
                      req_wdata[ARCH_WIDTH-1:8]};

  assign req_ready  = 1'b1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;

  assign w_sel      = uart_addr_t'(req_addr[3:2]);
  assign w_rd       = req_valid && (req_rtype == DMEM_READ);
  assign w_wr       = req_valid && (req_rtype == DMEM_WRITE);
  // A TX write while a frame is in flight is silently dropped.
  assign w_tx_start = w_wr && (w_sel == UART_TX) && w_tx_ready;

  uart_bit_engine #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_engine (
    .clk        (clk),
    .rst        (rst),
    .i_tx_start (w_tx_start),
    .i_tx_byte  (req_wdata[7:0]),
    .o_tx_ready (w_tx_ready),
    .o_uart_tx  (uart_tx),
    .i_uart_rx  (uart_rx),
    .o_rx_done  (w_rx_done),
    .o_rx_byte  (w_rx_byte)
  );

  // Build the status word and select the load data for the addressed register.
  always_comb begin
    w_ctrl          = '0;
    w_ctrl.rx_valid = r_rx_valid;
    w_ctrl.tx_ready = w_tx_ready;
    w_rd_data       = '0;
    case (w_sel)
      UART_CTRL: w_rd_data = w_ctrl;
      UART_RX:   w_rd_data = zext_byte(r_rx_data);
      UART_TX:   w_rd_data = zext_byte(r_tx_data);
      default:   w_rd_data = '0;
    endcase
  end

  // Response register: one-cycle valid pulse per read request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      if (w_rd) begin
        r_rsp_data <= w_rd_data;
      end
    end
  end

  // Received-byte holding register; a completing byte beats a same-cycle RX read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
    end else begin
      if (w_rx_done) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= w_rx_byte;
      end else if (w_rd && (w_sel == UART_RX)) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Last accepted TX byte, readable back through the TX register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= 8'd0;
    end else begin
      if (w_tx_start) begin
        r_tx_data <= req_wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder at 10 clocks per bit.
module tb_uart_mmio_responder;
  import uart_mmio_responder_pkg::*;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_RX   = BASE + 32'h4;
  localparam logic [31:0] A_TX   = BASE + 32'h8;
  localparam logic [31:0] A_NONE = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rtype;
  logic [2:0]  req_dtype;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        uart_rx, uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        rtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dtype;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  uart_mmio_responder #(
    .CLOCK_FREQ (1_152_000),
    .BAUD_RATE  (BR_115200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rtype (req_rtype),
    .req_dtype (req_dtype),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding read, one cycle late.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
  end

  // Called #1 after a rising edge; occupies exactly one request cycle.
  task automatic bus(input logic rtype, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] dtype, input logic [31:0] exp);
    exp_t e;
    req_valid = 1'b1;
    req_rtype = rtype;
    req_addr  = addr;
    req_wdata = wdata;
    req_dtype = dtype;
    if (rtype == DMEM_READ) begin
      e.data = exp;
      e.cyc  = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus(DMEM_READ, addr, 32'h0, DMEM_WORD, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    bus(DMEM_WRITE, addr, wdata, DMEM_WORD, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Checks the line every cycle from the write cycle through a trailing idle window.
  task automatic check_tx_frame(input logic [7:0] b, input int tail);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(negedge clk);
    check("tx_pre", 32'(uart_tx), 32'd1);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      check("tx_bit", 32'(uart_tx), 32'(f[j / 10]));
    end
    for (int j = 0; j < tail; j++) begin
      @(negedge clk);
      check("tx_idle_after", 32'(uart_tx), 32'd1);
    end
  endtask

  // Drives one 10-clk-per-bit frame, then holds the line high for 4 cycles.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (10) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    vecs[0]  = '{DMEM_READ,  A_CTRL,          32'h0,  DMEM_WORD, 32'h1};
    vecs[1]  = '{DMEM_READ,  A_RX,            32'h0,  DMEM_WORD, 32'h0};
    vecs[2]  = '{DMEM_READ,  A_TX,            32'h0,  DMEM_WORD, 32'h0};
    vecs[3]  = '{DMEM_READ,  A_NONE,          32'h0,  DMEM_WORD, 32'h0};
    vecs[4]  = '{DMEM_READ,  A_CTRL + 32'h3,  32'h0,  DMEM_BYTE, 32'h1};
    vecs[5]  = '{DMEM_WRITE, A_CTRL,          32'hFF, DMEM_WORD, 32'h0};
    vecs[6]  = '{DMEM_WRITE, A_RX,            32'hFF, DMEM_WORD, 32'h0};
    vecs[7]  = '{DMEM_WRITE, A_NONE,          32'hFF, DMEM_WORD, 32'h0};
    vecs[8]  = '{DMEM_READ,  A_CTRL,          32'h0,  DMEM_HALF, 32'h1};
    vecs[9]  = '{DMEM_READ,  A_RX + 32'h2,    32'h0,  DMEM_HALF, 32'h0};
    vecs[10] = '{DMEM_READ,  A_TX + 32'h3,    32'h0,  DMEM_BYTE, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_rtype = 1'b0; req_dtype = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; uart_rx = 1'b1;
    @(posedge clk); #1;
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("req_ready", 32'(req_ready), 32'd1);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Register map, ignored writes and addr[1:0]/dtype independence.
    for (int i = 0; i < 11; i++) begin
      bus(vecs[i].rtype, vecs[i].addr, vecs[i].wdata, vecs[i].dtype, vecs[i].exp);
      check("vec_uart_tx_idle", 32'(uart_tx), 32'd1);
    end
    idle(3);

    // TX 0xA5 frame; busy write of 0x3C dropped; ready returns at write+101.
    n0 = cyc;
    fork
      check_tx_frame(8'hA5, 30);
      begin
        wr(A_TX, 32'hA5);
        wait_until(n0 + 20);
        wr(A_TX, 32'h3C);
        wait_until(n0 + 50);
        rd(A_CTRL, 32'h0);
        wait_until(n0 + 100);
        rd(A_CTRL, 32'h0);
        rd(A_CTRL, 32'h1);
        rd(A_TX, 32'hA5);
      end
    join
    @(posedge clk); #1;

    // RX byte, then read-to-clear.
    send_rx(8'h5A, 1'b1);
    rd(A_CTRL, 32'h3);
    rd(A_RX, 32'h5A);
    rd(A_CTRL, 32'h1);

    // Short low glitch must not produce a byte.
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(30);
    rd(A_CTRL, 32'h1);
    rd(A_RX, 32'h5A);

    // Framing error discards the byte.
    send_rx(8'h11, 1'b0);
    idle(3);
    rd(A_CTRL, 32'h1);
    rd(A_RX, 32'h5A);

    // Overrun: second byte overwrites the first.
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    rd(A_CTRL, 32'h3);
    rd(A_RX, 32'h33);
    rd(A_CTRL, 32'h1);

    // RX read in the cycle the 0x77 byte lands: old byte returned, new byte kept.
    fork
      send_rx(8'h77, 1'b1);
      begin
        repeat (98) @(posedge clk);
        #1;
        rd(A_RX, 32'h33);
      end
    join
    rd(A_CTRL, 32'h3);
    rd(A_RX, 32'h77);
    rd(A_CTRL, 32'h1);

    // Reset in the middle of a TX frame of zeros.
    wr(A_TX, 32'h00);
    idle(40);
    check("tx_mid_frame_low", 32'(uart_tx), 32'd0);
    #2 rst = 1'b1;
    #1 check("tx_async_reset", 32'(uart_tx), 32'd1);
    idle(2);
    rst = 1'b0;
    rd(A_CTRL, 32'h1);
    rd(A_TX, 32'h0);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("tx_after_reset", 32'(uart_tx), 32'd1);
    end
    @(posedge clk); #1;
    idle(3);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_responder.md
Name: uart_mmio_responder

Overview:
- MMIO-side responder for core data requests in `MMIO_RANGE`. It is the consumer end of the `rv_if_dc` RX modport.
- Decodes the three UART registers {ctrl, rx_data, tx_data} (`UART_SIZE` = 12 B) and returns load data one cycle later.
- Contains the serial TX shifter and the RX deserializer that drive and sample the board UART pins.

Parameters:
- CLOCK_FREQ, 100_000_000, core clock in Hz.
- BAUD_RATE, BR_115200, a `uart_baud_rate_t` value.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (localparam), integer division, truncated; must be >= 4.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid (`rv_if_dc` RX modport)
- req_ready  out  1  responder ready; tied 1
- req_rtype  in  1  `dmem_rtype_t`
- req_dtype  in  3  `dmem_dtype_t`
- req_addr  in  ARCH_WIDTH  byte address; addr[3:2] selects the register
- req_wdata  in  ARCH_WIDTH  store data
- rsp_valid  out  1  load data valid, one cycle after a read request
- rsp_data  out  ARCH_WIDTH  load data
- uart_rx  in  1  serial input; asynchronous to clk
- uart_tx  out  1  serial output; idle high

Behaviour:
- Reset (async):
  - uart_tx=1, rsp_valid=0, rsp_data=0.
  - rx_valid=0, rx_data=0, tx_ready=1.
  - Both FSMs in IDLE; counters 0.
- Decode: addr[3:2] is a `uart_addr_t`.
  - addr[3:2]=3 (unmapped): reads return 0; writes are ignored.
  - addr[1:0] is ignored.
- Read (req_valid & rtype=DMEM_READ):
  - Next cycle: rsp_valid=1 and rsp_data holds:
    - CTRL: {30'b0, rx_valid, tx_ready} (`uart_ctrl_t`)
    - RX: {24'b0, rx_data}
    - TX: {24'b0, last written byte}
  - dtype is ignored for reads; data is always zero-extended.
  - rsp_valid is high for exactly one cycle per request.
- RX read side effect: reading RX clears rx_valid at the clock edge of the request.
- Write (rtype=DMEM_WRITE):
  - TX with tx_ready=1: latches wdata[7:0], tx_ready→0 the next cycle, frame starts.
  - TX with tx_ready=0: write is dropped; no error is flagged.
  - Writes to CTRL or RX: ignored.
  - Writes produce no response (rsp_valid stays 0).
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each bit lasts CLKS_PER_BIT cycles.
  - uart_tx is registered; the start bit appears the cycle after the accepting write.
  - tx_ready→1 on the cycle STOP completes.
  - Back-to-back writes give frames with no idle gap.
- RX FSM: IDLE → START → DATA → STOP.
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a CLKS_PER_BIT/2 count to mid-start.
  - If the mid-start sample is 1, the start is a glitch: return to IDLE.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first.
  - Stop sample = 1: rx_data updated, rx_valid=1.
  - Stop sample = 0 (framing error): byte discarded, rx_valid unchanged.
  - After STOP, the FSM returns to IDLE and waits for the line high before re-arming.
- Overrun: a new byte arriving while rx_valid=1 overwrites rx_data; rx_valid stays 1.
- Simultaneous RX read and byte completion in the same cycle: the new byte wins.
  - rx_valid=1 and rx_data=new byte afterwards.
  - The read returns the old byte.
- Reset mid-frame: uart_tx returns high immediately (async); any partial RX byte is lost.

Decomposition:
- Shared package holds `uart_addr_t`, `uart_ctrl_t`, `uart_baud_rate_t`, `UART_SIZE`, `dmem_rtype_t` and `dmem_dtype_t`.
- Add new enums `uart_tx_state_t` and `uart_rx_state_t` {IDLE, START, DATA, STOP} to the same package.
- One sub-module, `uart_bit_engine`, holds the TX shifter and the RX deserializer with their baud counters.
- The top level keeps register decode and the response register.

Test Plan:
- Bench config for all scenarios: CLOCK_FREQ=1_152_000, BR_115200, so CLKS_PER_BIT=10.
- Reset, then read CTRL → rsp_valid exactly 1 cycle later, rsp_data=0x1; uart_tx=1 throughout.
- Write TX 0xA5 → frame 0,1,0,1,0,0,1,0,1,1, each bit 10 clk.
  - CTRL reads 0x0 during the frame and 0x1 from cycle 101 after the write.
- Write TX 0x3C while busy → dropped; only the 0xA5 frame appears, and a TX read returns 0xA5.
- Drive uart_rx with byte 0x5A → CTRL=0x3.
  - RX read returns 0x5A, next CTRL=0x1.
  - A 4-clk low glitch on idle uart_rx produces no byte.
- Drive byte 0x11 with stop bit = 0 → rx_valid stays 0.
  - Then drive 0x22 then 0x33 without reading → an RX read returns 0x33.
- Issue an RX read in the exact cycle the 0x77 stop bit completes → read returns the old byte, and afterwards CTRL=0x3 with rx_data=0x77.
- Assert rst mid-TX-frame → uart_tx=1 in the same cycle (async), and CTRL=0x1 after release.
